// File: rtl/mem_stage_if.sv
// Bus bundle for the RV32I memory stage: EX/MEM entry, data-memory port and MEM/WB entry.
// The stage itself uses the slave view; the surrounding pipeline or environment uses master.
interface mem_stage_if;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [4:0]  in_rd_addr;
  logic        in_regfile_we;
  logic [31:0] in_alu_result;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_store_data;
  logic        stall_out;

  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        wb_regfile_we;
  logic        wb_misaligned;

  modport slave (
    input  in_valid, in_pc, in_rd_addr, in_regfile_we, in_alu_result,
           in_is_load, in_is_store, in_funct3, in_store_data,
           dmem_rdata, dmem_resp,
    output stall_out, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           wb_valid, wb_pc, wb_rd_addr, wb_rd_data, wb_regfile_we, wb_misaligned
  );

  modport master (
    output in_valid, in_pc, in_rd_addr, in_regfile_we, in_alu_result,
           in_is_load, in_is_store, in_funct3, in_store_data,
           dmem_rdata, dmem_resp,
    input  stall_out, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           wb_valid, wb_pc, wb_rd_addr, wb_rd_data, wb_regfile_we, wb_misaligned
  );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues one data-memory access per load/store, waits for the
// response, aligns/extends load data and registers the MEM/WB entry.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [1:0]      off;
  logic            is_mem;
  logic            size_mis;
  logic            misaligned;
  logic            mem_op;
  logic [3:0]      acc_mask;

  logic            stall;
  logic [3:0]      rmask;
  logic [3:0]      wmask;

  logic [XLEN-1:0] hold_pc;
  logic [RW-1:0]   hold_rd;
  logic [2:0]      hold_f3;
  logic [1:0]      hold_off;
  logic            hold_ld;

  logic [XLEN-1:0] load_shift;
  logic [XLEN-1:0] load_ext;

  logic            wb_valid;
  logic [XLEN-1:0] wb_pc;
  logic [RW-1:0]   wb_rd_addr;
  logic [XLEN-1:0] wb_rd_data;
  logic            wb_regfile_we;
  logic            wb_misaligned;

  // Access decode: byte lanes and natural-alignment check from funct3 size and offset
  always_comb begin
    off      = bus.in_alu_result[1:0];
    is_mem   = bus.in_valid & (bus.in_is_load | bus.in_is_store);
    acc_mask = 4'b1111;
    size_mis = 1'b0;
    case (bus.in_funct3[1:0])
      2'b00: acc_mask = 4'b0001 << off;
      2'b01: begin
        acc_mask = 4'b0011 << off;
        size_mis = off[0];
      end
      default: begin
        acc_mask = 4'b1111;
        size_mis = (off != 2'b00);
      end
    endcase
    misaligned = is_mem & size_mis;
    mem_op     = is_mem & ~size_mis;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mem_op)        state_nxt = S_WAIT;
      S_WAIT:  if (bus.dmem_resp) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: request strobes exist only in the issue cycle
  always_comb begin
    stall = 1'b0;
    rmask = 4'b0000;
    wmask = 4'b0000;
    case (state)
      S_IDLE: begin
        stall = mem_op;
        if (mem_op) begin
          if (bus.in_is_load) rmask = acc_mask;
          else                wmask = acc_mask;
        end
      end
      S_WAIT:  stall = ~bus.dmem_resp;
      default: stall = 1'b0;
    endcase
  end

  // Load alignment and extension from the held offset and funct3
  always_comb begin
    load_shift = bus.dmem_rdata >> {hold_off, 3'b000};
    case (hold_f3)
      3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_ext = {24'd0, load_shift[7:0]};
      3'b101:  load_ext = {16'd0, load_shift[15:0]};
      default: load_ext = load_shift;
    endcase
  end

  // Hold registers and MEM/WB entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_pc       <= '0;
      hold_rd       <= '0;
      hold_f3       <= '0;
      hold_off      <= '0;
      hold_ld       <= 1'b0;
      wb_valid      <= 1'b0;
      wb_pc         <= '0;
      wb_rd_addr    <= '0;
      wb_rd_data    <= '0;
      wb_regfile_we <= 1'b0;
      wb_misaligned <= 1'b0;
    end else if (state == S_IDLE) begin
      if (mem_op) begin
        hold_pc  <= bus.in_pc;
        hold_rd  <= bus.in_rd_addr;
        hold_f3  <= bus.in_funct3;
        hold_off <= off;
        hold_ld  <= bus.in_is_load;
        wb_valid <= 1'b0;
      end else begin
        wb_valid      <= bus.in_valid;
        wb_pc         <= bus.in_pc;
        wb_rd_addr    <= bus.in_rd_addr;
        wb_rd_data    <= bus.in_alu_result;
        wb_regfile_we <= bus.in_regfile_we & ~misaligned;
        wb_misaligned <= misaligned;
      end
    end else if (bus.dmem_resp) begin
      wb_valid      <= 1'b1;
      wb_pc         <= hold_pc;
      wb_rd_addr    <= hold_rd;
      wb_rd_data    <= hold_ld ? load_ext : XLEN'(0);
      wb_regfile_we <= hold_ld;
      wb_misaligned <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  assign bus.stall_out     = stall;
  assign bus.dmem_addr     = {bus.in_alu_result[31:2], 2'b00};
  assign bus.dmem_rmask    = rmask;
  assign bus.dmem_wmask    = wmask;
  assign bus.dmem_wdata    = bus.in_store_data << {off, 3'b000};
  assign bus.wb_valid      = wb_valid;
  assign bus.wb_pc         = wb_pc;
  assign bus.wb_rd_addr    = wb_rd_addr;
  assign bus.wb_rd_data    = wb_rd_data;
  assign bus.wb_regfile_we = wb_regfile_we;
  assign bus.wb_misaligned = wb_misaligned;

endmodule
